// File: rtl/tle_tile_sequencer_if.sv
// rtl/tle_tile_sequencer_if.sv - command, tile, datapath and result handshakes of the tile sequencer
interface tle_tile_sequencer_if #(
  parameter int M    = 2,
  parameter int N    = 2,
  parameter int P    = 8,
  parameter int KT_W = 8
);
  logic                                  cmd_valid_i;
  logic                                  cmd_ready_o;
  logic [KT_W-1:0]                       cmd_ktiles_i;
  logic signed [M-1:0][N-1:0][4*P-1:0]   bias_i;

  logic                                  tile_valid_i;
  logic                                  tile_ready_o;
  logic [KT_W-1:0]                       kidx_o;

  logic                                  dp_valid_o;
  logic                                  dp_ready_i;
  logic signed [M-1:0][N-1:0][4*P-1:0]   dp_C_o;

  logic                                  dp_valid_i;
  logic                                  dp_ready_o;
  logic signed [M-1:0][N-1:0][4*P-1:0]   dp_D_i;

  logic                                  res_valid_o;
  logic                                  res_ready_i;
  logic signed [M-1:0][N-1:0][4*P-1:0]   res_D_o;

  logic                                  busy_o;
  logic [15:0]                           jobs_done_o;

  modport slave (
    input  cmd_valid_i, cmd_ktiles_i, bias_i, tile_valid_i, dp_ready_i,
           dp_valid_i, dp_D_i, res_ready_i,
    output cmd_ready_o, tile_ready_o, kidx_o, dp_valid_o, dp_C_o,
           dp_ready_o, res_valid_o, res_D_o, busy_o, jobs_done_o
  );

  modport master (
    output cmd_valid_i, cmd_ktiles_i, bias_i, tile_valid_i, dp_ready_i,
           dp_valid_i, dp_D_i, res_ready_i,
    input  cmd_ready_o, tile_ready_o, kidx_o, dp_valid_o, dp_C_o,
           dp_ready_o, res_valid_o, res_D_o, busy_o, jobs_done_o
  );
endinterface

// File: rtl/tle_tile_sequencer.sv
// rtl/tle_tile_sequencer.sv - sequences K tiles through an external MAC datapath, one tile in flight
module tle_tile_sequencer #(
  parameter int M    = 2,
  parameter int N    = 2,
  parameter int P    = 8,
  parameter int KT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  tle_tile_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t                                r_state;
  logic signed [M-1:0][N-1:0][4*P-1:0]   r_acc;
  logic [KT_W-1:0]                       r_kcnt;
  logic [KT_W-1:0]                       r_ktiles;
  logic [15:0]                           r_jobs_done;
  logic                                  r_cmd_ready;
  logic                                  r_dp_ready;
  logic                                  r_res_valid;
  logic                                  r_busy;
  logic                                  w_issue;

  // The issue stage is a pure pass-through so a tile costs no extra cycle.
  assign w_issue          = (r_state == ISSUE);
  assign bus.dp_valid_o   = w_issue & bus.tile_valid_i;
  assign bus.tile_ready_o = w_issue & bus.dp_ready_i;

  assign bus.cmd_ready_o  = r_cmd_ready;
  assign bus.dp_ready_o   = r_dp_ready;
  assign bus.res_valid_o  = r_res_valid;
  assign bus.busy_o       = r_busy;
  assign bus.jobs_done_o  = r_jobs_done;
  assign bus.kidx_o       = r_kcnt;
  assign bus.dp_C_o       = r_acc;
  assign bus.res_D_o      = r_acc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_kcnt      <= '0;
      r_ktiles    <= '0;
      r_jobs_done <= '0;
      r_cmd_ready <= 1'b0;
      r_dp_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (bus.cmd_valid_i && r_cmd_ready) begin
            r_ktiles    <= bus.cmd_ktiles_i;
            r_acc       <= bus.bias_i;
            r_kcnt      <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.cmd_ktiles_i == '0) begin
              r_state     <= OUT;
              r_res_valid <= 1'b1;
            end else begin
              r_state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.tile_valid_i && bus.dp_ready_i) begin
            r_kcnt     <= r_kcnt + 1'b1;
            r_dp_ready <= 1'b1;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          // kcnt already counts the returning tile, so equality means the last one is back.
          if (bus.dp_valid_i) begin
            r_acc      <= bus.dp_D_i;
            r_dp_ready <= 1'b0;
            if (r_kcnt == r_ktiles) begin
              r_state     <= OUT;
              r_res_valid <= 1'b1;
            end else begin
              r_state     <= ISSUE;
            end
          end
        end
        OUT: begin
          if (bus.res_ready_i) begin
            r_jobs_done <= r_jobs_done + 16'd1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tle_tile_sequencer.sv
// tb/tb_tle_tile_sequencer.sv - randomized self-checking bench for the tile sequencer
module tb_tle_tile_sequencer;

  localparam int M    = 2;
  localparam int N    = 2;
  localparam int P    = 8;
  localparam int KT_W = 8;
  localparam int KD   = 2;

  typedef logic [M-1:0][N-1:0][4*P-1:0] mat_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   jobs_model = 0;

  always #5 clk_i = ~clk_i;

  tle_tile_sequencer_if #(.M(M), .N(N), .P(P), .KT_W(KT_W)) bus ();

  tle_tile_sequencer #(.M(M), .N(N), .P(P), .KT_W(KT_W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive_idle();
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_ktiles_i = '0;
    bus.bias_i       = '0;
    bus.tile_valid_i = 1'b0;
    bus.dp_ready_i   = 1'b0;
    bus.dp_valid_i   = 1'b0;
    bus.dp_D_i       = '0;
    bus.res_ready_i  = 1'b0;
  endtask

  function automatic mat_t fill(input int v);
    mat_t m;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = v[4*P-1:0];
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = $urandom;
    return m;
  endfunction

  // One full job; expected accumulator = bias + sum over tiles of K*A*B.
  task automatic run_job(input int kt, input mat_t bias, input int issue_stall,
                         input int res_stall, input bit stray, input int abort_k,
                         input bit fixed_ab);
    mat_t exp_m, c_seen, d_drv;
    int   budget, a, b, prod, st, lat;
    exp_m  = bias;
    budget = 0;
    while (bus.cmd_ready_o !== 1'b1 && budget < 20) begin
      step();
      budget++;
    end
    n_checks++;
    if (budget >= 20) begin
      n_errors++;
      $display("FAIL cmd_ready_timeout: got %0b expected 1", bus.cmd_ready_o);
    end
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_ktiles_i = kt[KT_W-1:0];
    bus.bias_i       = bias;
    step();
    bus.cmd_valid_i  = 1'b0;
    bus.bias_i       = rand_mat();
    #1;
    n_checks++;
    if ({bus.busy_o, bus.cmd_ready_o} !== 2'b10) begin
      n_errors++;
      $display("FAIL accept_busy: got busy,cmd_ready=%b expected 10", {bus.busy_o, bus.cmd_ready_o});
    end
    for (int k = 0; k < kt; k++) begin
      if (fixed_ab) begin
        a = 1;
        b = 2;
      end else begin
        a = int'($urandom_range(0, 15)) - 8;
        b = int'($urandom_range(0, 15)) - 8;
      end
      prod = KD * a * b;
      st   = (issue_stall >= 0) ? issue_stall : int'($urandom_range(0, 2));
      bus.tile_valid_i = 1'b1;
      bus.dp_ready_i   = 1'b0;
      for (int s = 0; s < st; s++) begin
        bus.dp_valid_i = stray;
        bus.dp_D_i     = rand_mat();
        #1;
        n_checks++;
        if ({bus.tile_ready_o, bus.dp_valid_o, bus.dp_ready_o, bus.res_valid_o, bus.busy_o} !== 5'b01001
            || bus.kidx_o !== k[KT_W-1:0] || bus.dp_C_o !== exp_m) begin
          n_errors++;
          $display("FAIL issue_stall: tile %0d got tr,dv,dr,rv,busy=%b kidx=%0d C=%h expected 01001 kidx=%0d C=%h",
                   k, {bus.tile_ready_o, bus.dp_valid_o, bus.dp_ready_o, bus.res_valid_o, bus.busy_o},
                   bus.kidx_o, bus.dp_C_o, k, exp_m);
        end
        step();
      end
      bus.dp_ready_i = 1'b1;
      bus.dp_valid_i = stray;
      #1;
      c_seen = bus.dp_C_o;
      n_checks++;
      if ({bus.tile_ready_o, bus.dp_valid_o, bus.dp_ready_o} !== 3'b110
          || bus.kidx_o !== k[KT_W-1:0] || c_seen !== exp_m) begin
        n_errors++;
        $display("FAIL issue_handshake: tile %0d got tr,dv,dr=%b kidx=%0d C=%h expected 110 kidx=%0d C=%h",
                 k, {bus.tile_ready_o, bus.dp_valid_o, bus.dp_ready_o}, bus.kidx_o, c_seen, k, exp_m);
      end
      step();
      bus.dp_valid_i = 1'b0;
      #1;
      n_checks++;
      if ({bus.tile_ready_o, bus.dp_valid_o, bus.dp_ready_o} !== 3'b001
          || bus.kidx_o !== 8'(k + 1)) begin
        n_errors++;
        $display("FAIL wait_entry: tile %0d got tr,dv,dr=%b kidx=%0d expected 001 kidx=%0d",
                 k, {bus.tile_ready_o, bus.dp_valid_o, bus.dp_ready_o}, bus.kidx_o, k + 1);
      end
      if (k == abort_k) begin
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({bus.cmd_ready_o, bus.tile_ready_o, bus.dp_valid_o, bus.dp_ready_o, bus.res_valid_o, bus.busy_o} !== 6'b0
            || bus.jobs_done_o !== 16'd0 || bus.kidx_o !== '0 || bus.dp_C_o !== '0) begin
          n_errors++;
          $display("FAIL abort_reset: got cr,tr,dv,dr,rv,busy=%b jobs=%0d kidx=%0d C=%h expected all 0",
                   {bus.cmd_ready_o, bus.tile_ready_o, bus.dp_valid_o, bus.dp_ready_o, bus.res_valid_o, bus.busy_o},
                   bus.jobs_done_o, bus.kidx_o, bus.dp_C_o);
        end
        jobs_model = 0;
        drive_idle();
        step();
        step();
        rst_ni = 1'b1;
        step();
        return;
      end
      lat = int'($urandom_range(0, 3));
      for (int s = 0; s < lat; s++) step();
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++) begin
          d_drv[i][j] = c_seen[i][j] + prod[4*P-1:0];
          exp_m[i][j] = exp_m[i][j] + prod[4*P-1:0];
        end
      bus.dp_valid_i = 1'b1;
      bus.dp_D_i     = d_drv;
      step();
      bus.dp_valid_i   = 1'b0;
      bus.tile_valid_i = 1'b0;
      bus.dp_ready_i   = 1'b0;
    end
    bus.tile_valid_i = 1'b1;
    bus.dp_ready_i   = 1'b1;
    #1;
    n_checks++;
    if (bus.res_valid_o !== 1'b1 || bus.res_D_o !== exp_m || bus.kidx_o !== kt[KT_W-1:0]
        || {bus.tile_ready_o, bus.dp_valid_o, bus.dp_ready_o} !== 3'b000) begin
      n_errors++;
      $display("FAIL out_entry: kt %0d got rv=%b D=%h kidx=%0d tr,dv,dr=%b expected rv=1 D=%h kidx=%0d 000",
               kt, bus.res_valid_o, bus.res_D_o, bus.kidx_o,
               {bus.tile_ready_o, bus.dp_valid_o, bus.dp_ready_o}, exp_m, kt);
    end
    for (int s = 0; s < res_stall; s++) begin
      step();
      #1;
      n_checks++;
      if (bus.res_valid_o !== 1'b1 || bus.res_D_o !== exp_m || bus.cmd_ready_o !== 1'b0) begin
        n_errors++;
        $display("FAIL res_hold: cycle %0d got rv=%b D=%h cr=%b expected rv=1 D=%h cr=0",
                 s, bus.res_valid_o, bus.res_D_o, bus.cmd_ready_o, exp_m);
      end
    end
    bus.tile_valid_i = 1'b0;
    bus.dp_ready_i   = 1'b0;
    bus.res_ready_i  = 1'b1;
    step();
    bus.res_ready_i  = 1'b0;
    jobs_model = (jobs_model + 1) & 16'hFFFF;
    #1;
    n_checks++;
    if ({bus.res_valid_o, bus.busy_o, bus.cmd_ready_o} !== 3'b001 || bus.jobs_done_o !== jobs_model[15:0]) begin
      n_errors++;
      $display("FAIL job_done: got rv,busy,cr=%b jobs=%0d expected 001 jobs=%0d",
               {bus.res_valid_o, bus.busy_o, bus.cmd_ready_o}, bus.jobs_done_o, jobs_model);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_ni = 1'b0;
    step();
    step();
    bus.tile_valid_i = 1'b1;
    bus.dp_ready_i   = 1'b1;
    bus.dp_valid_i   = 1'b1;
    #1;
    n_checks++;
    if ({bus.cmd_ready_o, bus.tile_ready_o, bus.dp_valid_o, bus.dp_ready_o, bus.res_valid_o, bus.busy_o} !== 6'b0
        || bus.jobs_done_o !== 16'd0 || bus.kidx_o !== '0 || bus.dp_C_o !== '0 || bus.res_D_o !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got cr,tr,dv,dr,rv,busy=%b jobs=%0d kidx=%0d C=%h expected all 0",
               {bus.cmd_ready_o, bus.tile_ready_o, bus.dp_valid_o, bus.dp_ready_o, bus.res_valid_o, bus.busy_o},
               bus.jobs_done_o, bus.kidx_o, bus.dp_C_o);
    end
    drive_idle();
    rst_ni = 1'b1;
    step();
    #1;
    n_checks++;
    if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got cr=%b busy=%b expected cr=1 busy=0", bus.cmd_ready_o, bus.busy_o);
    end
    jobs_model = 0;
  endtask

  task automatic test_basic();
    run_job(3, fill(3), -1, 0, 1'b0, -1, 1'b1);
    n_checks++;
    if (bus.res_D_o !== fill(15) || bus.jobs_done_o !== 16'd1) begin
      n_errors++;
      $display("FAIL basic_result: got D=%h jobs=%0d expected D=%h jobs=1", bus.res_D_o, bus.jobs_done_o, fill(15));
    end
  endtask

  task automatic test_zero_ktiles();
    run_job(0, fill(-7), -1, 2, 1'b0, -1, 1'b0);
    n_checks++;
    if (bus.res_D_o !== fill(-7)) begin
      n_errors++;
      $display("FAIL zero_ktiles_result: got D=%h expected %h", bus.res_D_o, fill(-7));
    end
  endtask

  task automatic test_issue_stall();
    run_job(2, rand_mat(), 5, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_res_backpressure();
    run_job(1, rand_mat(), 0, 10, 1'b0, -1, 1'b0);
  endtask

  task automatic test_stray_dp_valid();
    run_job(3, rand_mat(), 2, 1, 1'b1, -1, 1'b0);
  endtask

  task automatic test_reset_midjob();
    run_job(4, rand_mat(), -1, 0, 1'b0, 1, 1'b0);
    run_job(1, rand_mat(), -1, 1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      run_job(int'($urandom_range(0, 6)), rand_mat(), -1, int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), -1, 1'b0);
  endtask

  task automatic test_max_ktiles();
    run_job(255, rand_mat(), 0, 0, 1'b0, -1, 1'b0);
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic();
    test_zero_ktiles();
    test_issue_stall();
    test_res_backpressure();
    test_stray_dp_valid();
    test_reset_midjob();
    test_random();
    test_max_ktiles();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tle_tile_sequencer.md
TLE_TILE_SEQUENCER -- requirements
Module: tle_tile_sequencer

Interface
REQ-001 The block SHALL have parameter M, default 2, meaning output tile rows.
REQ-002 The block SHALL have parameter N, default 2, meaning output tile columns.
REQ-003 The block SHALL have parameter P, default 8, meaning operand precision; accumulator elements are 4*P bits signed.
REQ-004 The block SHALL have parameter KT_W, default 8, meaning the width of the K-tile count.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  asynchronous active-low reset.
REQ-006 The command port SHALL be: cmd_valid_i  in  1; cmd_ready_o  out  1; cmd_ktiles_i  in  KT_W  number of K tiles to accumulate; bias_i  in  signed 4*P [M][N]  initial accumulator value.
REQ-007 The upstream A/B tile stream handshake SHALL be: tile_valid_i  in  1; tile_ready_o  out  1; kidx_o  out  KT_W  index of the tile currently being requested.
REQ-008 The datapath issue side SHALL be: dp_valid_o  out  1; dp_ready_i  in  1; dp_C_o  out  signed 4*P [M][N]  accumulator value presented as C.
REQ-009 The datapath return side SHALL be: dp_valid_i  in  1; dp_ready_o  out  1; dp_D_i  in  signed 4*P [M][N]  datapath result D = A*B + C.
REQ-010 The result port SHALL be: res_valid_o  out  1; res_ready_i  in  1; res_D_o  out  signed 4*P [M][N]  final accumulated tile.
REQ-011 The status outputs SHALL be: busy_o  out  1  high when the FSM is not IDLE; jobs_done_o  out  16  count of completed jobs.

Function
REQ-012 The FSM SHALL have the states IDLE, ISSUE, WAIT and OUT.
REQ-013 In IDLE, cmd_ready_o SHALL be 1; on cmd_valid_i the block SHALL latch ktiles, set acc <= bias_i and kcnt <= 0, and move to OUT if ktiles==0, otherwise to ISSUE.
REQ-014 In ISSUE, dp_valid_o SHALL equal tile_valid_i and tile_ready_o SHALL equal dp_ready_i (combinational pass-through); on tile_valid_i&&dp_ready_i the block SHALL increment kcnt and move to WAIT.
REQ-015 Outside ISSUE, dp_valid_o and tile_ready_o SHALL be 0.
REQ-016 The block SHALL drive dp_C_o = acc in all states.
REQ-017 The block SHALL drive kidx_o = kcnt in all states.
REQ-018 In WAIT, dp_ready_o SHALL be 1; on dp_valid_i the block SHALL set acc <= dp_D_i and move to OUT if kcnt==ktiles, otherwise to ISSUE.
REQ-019 Outside WAIT, dp_ready_o SHALL be 0, so that a stray dp_valid_i is neither consumed nor allowed to alter acc.
REQ-020 Exactly one tile SHALL be in flight at a time, because C of tile k+1 depends on D of tile k.
REQ-021 Issue-to-return latency SHALL be set by the datapath; the block SHALL add no extra cycle beyond the registered state transition, so WAIT->ISSUE takes 1 cycle after dp_valid_i.
REQ-022 In OUT, res_valid_o SHALL be 1 and res_D_o SHALL equal acc, held stable until res_ready_i.
REQ-023 On the OUT handshake the block SHALL increment jobs_done_o (wrapping 0xFFFF->0) and return to IDLE.
REQ-024 res_valid_o SHALL be 0 outside OUT.
REQ-025 The block SHALL accept no command while busy: cmd_ready_o SHALL be 0 in ISSUE, WAIT and OUT.
REQ-026 When ktiles==(2^KT_W)-1, the block SHALL process all tiles and kcnt SHALL NOT wrap before completion.
REQ-027 The block SHALL perform no arithmetic on acc; it stores only, and overflow is the datapath's concern.

Reset
REQ-028 While rst_ni==0, the block SHALL hold the state at IDLE and clear acc, kcnt, ktiles and jobs_done_o to 0.
REQ-029 While rst_ni==0, all valid/ready outputs SHALL be 0 and busy_o SHALL be 0.
REQ-030 Reset asserted mid-job SHALL abort the job with no result emitted; after release the block SHALL be ready for a new command.

Verification
REQ-031 The bench SHALL cover: with syn_tle M=N=K=2, P=8 and A=1, B=2 each tile, cmd ktiles=3, bias=3 -> res_D_o all elements 15, jobs_done_o=1.
REQ-032 The bench SHALL cover: ktiles=0, bias=-7 -> no dp_valid_o, OUT reached 1 cycle after command accept, res_D_o all -7.
REQ-033 The bench SHALL cover: dp_ready_i held 0 for 5 cycles in ISSUE -> tile_ready_o stays 0, kidx_o stable, no state change.
REQ-034 The bench SHALL cover: res_ready_i held 0 for 10 cycles -> res_valid_o stays 1, res_D_o stable, cmd_ready_o stays 0.
REQ-035 The bench SHALL cover: rst_ni pulsed low during WAIT of tile 2 of 4 -> all outputs 0, IDLE; a new job of ktiles=1 then completes correctly.
REQ-036 The bench SHALL cover: dp_valid_i asserted while in ISSUE -> dp_ready_o=0 and acc unchanged.
